// File: rtl/run_sequencer.sv
// run_sequencer: sequences NPROG core runs, each a reset hold, a timed RUN phase and a one-cycle report.
module run_sequencer #(
  parameter int CW      = 16,
  parameter int NPROG   = 3,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 4000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          core_done,
  output logic          core_reset,
  output logic [1:0]    prog_sel,
  output logic          busy,
  output logic          run_valid,
  output logic [CW-1:0] run_cycles,
  output logic          run_timeout,
  output logic          all_done
);
  typedef enum logic [1:0] {IDLE, HOLD, RUN, REPORT} state_t;
  localparam int HW = RST_CYC > 1 ? $clog2(RST_CYC) : 1;
  state_t        state, state_n;
  logic [HW-1:0] hcnt;
  logic [CW-1:0] cyc, n;
  logic          hold_end, limit, last;
  assign n        = cyc + CW'(1);
  assign hold_end = hcnt == HW'(RST_CYC - 1);
  assign limit    = n == CW'(TIMEOUT);
  assign last     = prog_sel == 2'(NPROG - 1);
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (start ? HOLD : IDLE) :
              state == HOLD ? (hold_end ? RUN : HOLD) :
              state == RUN  ? (core_done || limit ? REPORT : RUN) :
                              (last ? IDLE : HOLD);
  end
  always_comb begin
    core_reset = state != RUN;
    busy       = state != IDLE;
    run_valid  = state == REPORT;
  end
  // Per-run counters and the report registers that outlive each run
  always_ff @(posedge clk) begin
    if (reset) begin
      prog_sel    <= '0;
      hcnt        <= '0;
      cyc         <= '0;
      run_cycles  <= '0;
      run_timeout <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          prog_sel <= '0;
          all_done <= 1'b0;
          hcnt     <= '0;
        end
        HOLD: begin
          hcnt <= hcnt + HW'(1);
          if (hold_end) cyc <= '0;
        end
        RUN: begin
          if (core_done) begin
            run_cycles  <= n;
            run_timeout <= 1'b0;
          end else if (limit) begin
            run_cycles  <= CW'(TIMEOUT);
            run_timeout <= 1'b1;
          end else cyc <= n;
        end
        REPORT: begin
          if (last) all_done <= 1'b1;
          else begin
            prog_sel <= prog_sel + 2'd1;
            hcnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed checks of run_sequencer with TIMEOUT=20 and default NPROG/RST_CYC.
module tb_run_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, core_done = 1'b0;
  logic        core_reset, busy, run_valid, run_timeout, all_done;
  logic [1:0]  prog_sel;
  logic [15:0] run_cycles;
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  run_sequencer #(.TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .start(start), .core_done(core_done),
    .core_reset(core_reset), .prog_sel(prog_sel), .busy(busy), .run_valid(run_valid),
    .run_cycles(run_cycles), .run_timeout(run_timeout), .all_done(all_done)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input logic exp_all_done);
    chk({tag, "_rst"}, core_reset, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, run_valid, 0);
    chk({tag, "_all_done"}, all_done, exp_all_done);
  endtask
  // Entered on the first HOLD cycle; leaves on the cycle after REPORT.
  task automatic run_prog(input int p, input int done_at, input int exp_cyc, input bit exp_to,
                          input bit noise);
    chk("hold_rst", core_reset, 1);
    chk("hold_busy", busy, 1);
    chk("hold_prog", prog_sel, p);
    chk("hold_all_done", all_done, 0);
    if (noise) begin
      start     = 1'b1;
      core_done = 1'b1;
    end
    step;
    chk("hold2_rst", core_reset, 1);
    chk("hold2_valid", run_valid, 0);
    step;
    start     = 1'b0;
    core_done = 1'b0;
    for (int k = 1; k <= exp_cyc; k++) begin
      chk("run_rst", core_reset, 0);
      chk("run_valid", run_valid, 0);
      core_done = (k == done_at);
      start     = noise && k == 2;
      step;
      start = 1'b0;
    end
    core_done = 1'b0;
    chk("rep_valid", run_valid, 1);
    chk("rep_cycles", run_cycles, exp_cyc);
    chk("rep_timeout", run_timeout, exp_to);
    chk("rep_rst", core_reset, 1);
    chk("rep_prog", prog_sel, p);
    step;
    chk("post_valid", run_valid, 0);
    chk("held_cycles", run_cycles, exp_cyc);
    chk("held_timeout", run_timeout, exp_to);
  endtask
  task automatic run_seq(input int d0, d1, d2, c0, c1, c2, input bit to, input bit noise);
    start = 1'b1;
    step;
    start = 1'b0;
    run_prog(0, d0, c0, to, noise);
    run_prog(1, d1, c1, to, noise);
    run_prog(2, d2, c2, to, noise);
    chk_idle("end", 1);
    step;
    chk_idle("end2", 1);
  endtask
  initial begin
    // Reset with a coincident start: reset wins
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    chk_idle("rst", 0);
    chk("rst_prog", prog_sel, 0);
    chk("rst_cycles", run_cycles, 0);
    chk("rst_timeout", run_timeout, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      chk_idle("idle", 0);
    end
    // Done on RUN cycles 5, 7, 9
    run_seq(5, 7, 9, 5, 7, 9, 0, 0);
    // Never done: each run times out at 20
    run_seq(0, 0, 0, 20, 20, 20, 1, 0);
    // Done on the limit cycle itself: done wins
    run_seq(20, 20, 20, 20, 20, 20, 0, 0);
    // Done on the very first RUN cycle
    run_seq(1, 1, 1, 1, 1, 1, 0, 0);
    // Stray starts in HOLD/RUN and done during HOLD change nothing
    run_seq(5, 7, 9, 5, 7, 9, 0, 1);
    // Reset on RUN cycle 3 of program 1 aborts the sequence
    start = 1'b1;
    step;
    start = 1'b0;
    run_prog(0, 4, 4, 0, 0);
    chk("abort_prog1", prog_sel, 1);
    step;
    step;
    step;
    step;
    chk("abort_run3", core_reset, 0);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk_idle("abort", 0);
    chk("abort_prog", prog_sel, 0);
    chk("abort_cycles", run_cycles, 0);
    chk("abort_timeout", run_timeout, 0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk_idle("abort_idle", 0);
    end
    run_seq(5, 7, 9, 5, 7, 9, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
